// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Epoch storage is sized for up to 2**(EPOCH_W_MAX-1) outstanding requests.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam int EPOCH_W_MAX = 8;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [EPOCH_W_MAX-1:0] epoch;
  } inflight_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Redirect, imem and decode-side signals of the fetch stage.
// FETCH_MISALIGN_TRAP_EN adds the if_misalign flag toward decode.
interface fetch_if;
  import fetch_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] fetch_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            if_misalign;
`endif

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    , output if_misalign
`endif
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    , input if_misalign
`endif
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; a flush may coincide with a push, which then
// becomes the only entry. Head reads as zero while empty.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, wrIdx;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];
  assign doPush  = push_i && (flush_i || !full_o);
  assign doPop   = pop_i && !empty_o && !flush_i;
  assign wrIdx   = flush_i ? '0 : wrPtr_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = doPush ? nextPtr('0) : '0;
      count_d = doPush ? CW'(1) : '0;
    end else begin
      if (doPush) wrPtr_d = nextPtr(wrPtr_q);
      if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
      count_d = count_q + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrIdx] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC register, in-order imem request issue and decode-side queue.
// FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap entry.
module fetch_unit import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              QUEUE_DEPTH     = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int EPOCH_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int ICW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int QCW     = $clog2(QUEUE_DEPTH + 1);

  logic [XLEN-1:0]    fetchPc_q, fetchPc_d, redirTarget;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               issueOk, reqFire, rspPop, keepRsp, trapRedirect, halted;
  inflight_t          inflPush, inflHead;
  logic [ICW-1:0]     inflCnt;
  logic               inflEmpty, inflFull;
  fetch_entry_t       outPush, outHead;
  logic [QCW-1:0]     outCnt;
  logic               outEmpty, outFull, outPushEn, outPop;
  logic               unusedSink;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q, halted_d;

  assign trapRedirect    = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign redirTarget     = bus.redirect_pc;
  assign halted          = halted_q;
  assign bus.if_misalign = outHead.misalign;
  assign unusedSink      = ^{inflFull, outFull, inflHead.epoch};

  // A misaligned target parks fetch until some later redirect restarts it.
  always_comb begin
    halted_d = halted_q;
    if (bus.redirect_valid) halted_d = trapRedirect;
  end

  always_ff @(posedge clk) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end
`else
  assign trapRedirect = 1'b0;
  assign redirTarget  = alignPc(bus.redirect_pc);
  assign halted       = 1'b0;
  assign unusedSink   = ^{inflFull, outFull, inflHead.epoch, outHead.misalign,
                          bus.redirect_pc[1:0]};
`endif

  // Credit counts both outstanding requests and buffered entries, so a
  // response always has room in the output queue.
  assign issueOk = !rst && !bus.redirect_valid && !halted &&
                   (int'(inflCnt) < MAX_OUTSTANDING) &&
                   (int'(inflCnt) + int'(outCnt) < QUEUE_DEPTH);

  assign bus.imem_req_valid = issueOk;
  assign bus.imem_req_addr  = fetchPc_q;
  assign bus.fetch_pc       = fetchPc_q;
  assign bus.if_valid       = !outEmpty;
  assign bus.if_pc          = outHead.pc;
  assign bus.if_instr       = outHead.instr;

  assign reqFire   = issueOk && bus.imem_req_ready;
  assign rspPop    = bus.imem_rsp_valid && !inflEmpty;
  assign keepRsp   = rspPop && !bus.redirect_valid &&
                     (inflHead.epoch[EPOCH_W-1:0] == epoch_q);
  assign outPushEn = keepRsp || trapRedirect;
  assign outPop    = bus.if_valid && bus.if_ready && !bus.redirect_valid;

  always_comb begin
    inflPush = '{pc: fetchPc_q, epoch: EPOCH_W_MAX'(epoch_q)};
    if (trapRedirect) outPush = '{pc: bus.redirect_pc, instr: INSTR_NOP, misalign: 1'b1};
    else              outPush = '{pc: inflHead.pc, instr: bus.imem_rsp_data, misalign: 1'b0};
  end

  always_comb begin
    fetchPc_d = fetchPc_q;
    epoch_d   = epoch_q;
    if (bus.redirect_valid) begin
      fetchPc_d = redirTarget;
      epoch_d   = epoch_q + EPOCH_W'(1);
    end else if (reqFire) begin
      fetchPc_d = fetchPc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc_q <= RESET_PC;
      epoch_q   <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      epoch_q   <= epoch_d;
    end
  end

  fetch_queue #(.WIDTH($bits(inflight_t)), .DEPTH(MAX_OUTSTANDING)) uInflight (
    .clk     (clk),
    .rst     (rst),
    .push_i  (reqFire),
    .data_i  (inflPush),
    .pop_i   (rspPop),
    .flush_i (1'b0),
    .head_o  (inflHead),
    .count_o (inflCnt),
    .empty_o (inflEmpty),
    .full_o  (inflFull)
  );

  fetch_queue #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QUEUE_DEPTH)) uOutQueue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (outPushEn),
    .data_i  (outPush),
    .pop_i   (outPop),
    .flush_i (bus.redirect_valid),
    .head_o  (outHead),
    .count_o (outCnt),
    .empty_o (outEmpty),
    .full_o  (outFull)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle imem model and decode logger.
// Build with FETCH_MISALIGN_TRAP_EN to exercise the misaligned-redirect trap.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rspHold = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] pending[$];
  logic [31:0] acceptLog[$];
  logic [31:0] popLog[$];

  fetch_if busIf();

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrFor(input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  // Imem answers one cycle after acceptance unless held; decode pops are logged.
  always @(negedge clk) begin
    if (rst) begin
      pending.delete();
      busIf.imem_rsp_valid = 1'b0;
      busIf.imem_rsp_data  = '0;
    end else begin
      if (!rspHold && pending.size() > 0) begin
        busIf.imem_rsp_valid = 1'b1;
        busIf.imem_rsp_data  = instrFor(pending.pop_front());
      end else begin
        busIf.imem_rsp_valid = 1'b0;
        busIf.imem_rsp_data  = '0;
      end
      if (busIf.imem_req_valid && busIf.imem_req_ready) begin
        pending.push_back(busIf.imem_req_addr);
        acceptLog.push_back(busIf.imem_req_addr);
      end
      if (busIf.if_valid && busIf.if_ready && !busIf.redirect_valid)
        popLog.push_back(busIf.if_pc);
    end
  end

  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic qr, input logic ir, input logic hold);
    @(posedge clk);
    #1;
    rst                  = r;
    busIf.redirect_valid = rv;
    busIf.redirect_pc    = rpc;
    busIf.imem_req_ready = qr;
    busIf.if_ready       = ir;
    rspHold              = hold;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    acceptLog.delete();
    popLog.delete();
  endtask

  initial begin
    busIf.redirect_valid = 1'b0;
    busIf.redirect_pc    = '0;
    busIf.imem_req_ready = 1'b0;
    busIf.if_ready       = 1'b0;

    // Reset state and streaming fetch.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_req_valid", 32'(busIf.imem_req_valid), 32'h0);
    checkOutput("rst_if_valid", 32'(busIf.if_valid), 32'h0);
    checkOutput("rst_if_pc", busIf.if_pc, 32'h0);
    checkOutput("rst_if_instr", busIf.if_instr, 32'h0);
    checkOutput("rst_fetch_pc", busIf.fetch_pc, 32'h0);
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("s_first_valid", 32'(busIf.imem_req_valid), 32'h1);
    checkOutput("s_first_addr", busIf.imem_req_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("s_pc_after1", busIf.fetch_pc, 32'h4);
    checkOutput("s_addr2", busIf.imem_req_addr, 32'h4);
    checkOutput("s_no_early_valid", 32'(busIf.if_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("s_if_valid_n2", 32'(busIf.if_valid), 32'h1);
    checkOutput("s_if_pc0", busIf.if_pc, 32'h0);
    checkOutput("s_if_instr0", busIf.if_instr, 32'h5A00_0003);
    checkOutput("s_credit_stall", 32'(busIf.imem_req_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("s_if_pc4", busIf.if_pc, 32'h4);
    checkOutput("s_addr3", busIf.imem_req_addr, 32'h8);
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("s_accept1", at(acceptLog, 1), 32'h4);
    checkOutput("s_accept3", at(acceptLog, 3), 32'hC);
    checkOutput("s_pop2", at(popLog, 2), 32'h8);

    // Mid-operation reset.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("mr_req_valid", 32'(busIf.imem_req_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("mr_fetch_pc", busIf.fetch_pc, 32'h0);
    checkOutput("mr_if_valid", 32'(busIf.if_valid), 32'h0);
    checkOutput("mr_if_pc", busIf.if_pc, 32'h0);

    // Decode stalled: exactly two requests, then in-order drain and resume.
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("st_no_issue", 32'(busIf.imem_req_valid), 32'h0);
      checkOutput("st_hold_pc", busIf.if_pc, 32'h0);
    end
    checkOutput("st_two_accepts", 32'(acceptLog.size()), 32'h2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("st_drain0", busIf.if_pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("st_drain4", busIf.if_pc, 32'h4);
    checkOutput("st_instr4", busIf.if_instr, 32'h5A00_0007);
    checkOutput("st_resume_addr", busIf.imem_req_addr, 32'h8);
    checkOutput("st_resume_valid", 32'(busIf.imem_req_valid), 32'h1);

    // Redirect with two requests in flight.
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
    checkOutput("rd_no_issue", 32'(busIf.imem_req_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("rd_fetch_pc", busIf.fetch_pc, 32'h100);
    checkOutput("rd_credit", 32'(busIf.imem_req_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("rd_addr", busIf.imem_req_addr, 32'h100);
    checkOutput("rd_valid", 32'(busIf.imem_req_valid), 32'h1);
    checkOutput("rd_drop0", 32'(busIf.if_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("rd_drop4", 32'(busIf.if_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("rd_first_pc", busIf.if_pc, 32'h100);
    checkOutput("rd_first_instr", busIf.if_instr, 32'h5A00_0103);

    // Request held by imem back-pressure.
    resetDut();
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("bp_addr", busIf.imem_req_addr, 32'h20);
      checkOutput("bp_fetch_pc", busIf.fetch_pc, 32'h20);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("bp_accept_addr", busIf.imem_req_addr, 32'h20);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("bp_advance", busIf.fetch_pc, 32'h24);

    // Back-to-back redirects with responses pending.
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
    checkOutput("bb_mid_pc", busIf.fetch_pc, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("bb_pc", busIf.fetch_pc, 32'h300);
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("bb_accept2", at(acceptLog, 2), 32'h300);
    checkOutput("bb_pop0", at(popLog, 0), 32'h300);
    checkOutput("bb_pop1", at(popLog, 1), 32'h304);

    // Misaligned redirect target.
    resetDut();
    applyStimulus(1'b0, 1'b1, 32'h102, 1'b1, 1'b0, 1'b0);
    checkOutput("ma_no_issue", 32'(busIf.imem_req_valid), 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("ma_valid", 32'(busIf.if_valid), 32'h1);
    checkOutput("ma_pc", busIf.if_pc, 32'h102);
    checkOutput("ma_instr", busIf.if_instr, 32'h0000_0013);
    checkOutput("ma_flag", 32'(busIf.if_misalign), 32'h1);
    checkOutput("ma_halt", 32'(busIf.imem_req_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("ma_popped", 32'(busIf.if_valid), 32'h0);
    checkOutput("ma_flag_clear", 32'(busIf.if_misalign), 32'h0);
    checkOutput("ma_still_halted", 32'(busIf.imem_req_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("ma_restart_valid", 32'(busIf.imem_req_valid), 32'h1);
    checkOutput("ma_restart_addr", busIf.imem_req_addr, 32'h40);
`else
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("al_fetch_pc", busIf.fetch_pc, 32'h100);
    checkOutput("al_addr", busIf.imem_req_addr, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("al_if_pc", busIf.if_pc, 32'h100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
